// File: rtl/transf_lineal_inv.sv
// Inverse planar rotation: world-frame Q13 acceleration back to body-frame 16-bit counts.
// One shared 32x16 multiplier, 6-state FSM. Define TLINV_ROUND_EN for round-half-up before each shift.
module transf_lineal_inv #(
  parameter int FRAC = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [31:0] XAc,
  input  logic signed [31:0] YAc,
  input  logic signed [31:0] ZAc,
  input  logic signed [15:0] sdseno,
  input  logic signed [15:0] sdcoseno,
  output logic signed [15:0] AcX,
  output logic signed [15:0] AcY,
  output logic signed [15:0] AcZ,
  output logic               Busy,
  output logic               Done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] M0   = 3'd1;
  localparam logic [2:0] M1   = 3'd2;
  localparam logic [2:0] M2   = 3'd3;
  localparam logic [2:0] M3   = 3'd4;
  localparam logic [2:0] FIN  = 3'd5;

  localparam int SH = 2 * FRAC;

`ifdef TLINV_ROUND_EN
  localparam logic signed [49:0] RND_XY = 50'sd1 <<< (SH - 1);
  localparam logic signed [49:0] RND_Z  = 50'sd1 <<< (FRAC - 1);
`else
  localparam logic signed [49:0] RND_XY = 50'sd0;
  localparam logic signed [49:0] RND_Z  = 50'sd0;
`endif

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
    logic signed [15:0] s;
    logic signed [15:0] c;
  } req_t;

  req_t               req;
  logic [2:0]         state;
  logic signed [49:0] acc;
  logic signed [15:0] xres;

  logic signed [31:0] op_a;
  logic signed [15:0] op_b;
  logic signed [47:0] prod;
  logic signed [49:0] prod_ext;
  logic signed [49:0] acc_sh;
  logic signed [49:0] z_ext;
  logic signed [49:0] z_sh;

  function automatic logic signed [15:0] sat16(input logic signed [49:0] v);
    if (v > 50'sd32767)       return 16'sh7fff;
    else if (v < -50'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  // Operand schedule for the shared multiplier: cX, sY, cY, sX.
  always_comb begin
    op_a = req.x;
    op_b = req.c;
    case (state)
      M0:      begin op_a = req.x; op_b = req.c; end
      M1:      begin op_a = req.y; op_b = req.s; end
      M2:      begin op_a = req.y; op_b = req.c; end
      M3:      begin op_a = req.x; op_b = req.s; end
      default: begin op_a = req.x; op_b = req.c; end
    endcase
  end

  assign prod     = op_a * op_b;
  assign prod_ext = {{2{prod[47]}}, prod};
  assign acc_sh   = (acc + RND_XY) >>> SH;
  assign z_ext    = {{18{req.z[31]}}, req.z};
  assign z_sh     = (z_ext + RND_Z) >>> FRAC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req   <= '0;
      acc   <= '0;
      xres  <= '0;
      AcX   <= '0;
      AcY   <= '0;
      AcZ   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          req   <= '{x: XAc, y: YAc, z: ZAc, s: sdseno, c: sdcoseno};
          state <= M0;
          Busy  <= 1'b1;
        end
        M0: begin
          acc   <= prod_ext;
          state <= M1;
        end
        M1: begin
          acc   <= acc + prod_ext;
          state <= M2;
        end
        M2: begin
          xres  <= sat16(acc_sh);
          acc   <= prod_ext;
          state <= M3;
        end
        M3: begin
          acc   <= acc - prod_ext;
          state <= FIN;
        end
        FIN: begin
          AcX   <= xres;
          AcY   <= sat16(acc_sh);
          AcZ   <= sat16(z_sh);
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transf_lineal_inv.sv
// Scoreboard bench for transf_lineal_inv: stimulus pushes expected results, a monitor pops on Done.
module tb_transf_lineal_inv;
  logic clk = 1'b0;
  logic rst, enable;
  logic signed [31:0] XAc, YAc, ZAc;
  logic signed [15:0] sdseno, sdcoseno;
  logic signed [15:0] AcX, AcY, AcZ;
  logic Busy, Done;

  always #5 clk = ~clk;

  transf_lineal_inv #(.FRAC(13)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .XAc(XAc), .YAc(YAc), .ZAc(ZAc),
    .sdseno(sdseno), .sdcoseno(sdcoseno),
    .AcX(AcX), .AcY(AcY), .AcZ(AcZ),
    .Busy(Busy), .Done(Done)
  );

  typedef struct { shortint x; shortint y; shortint z; int due; } exp_t;
  exp_t q[$];
  exp_t last;
  int errs = 0, checks = 0, cyc = 0, ndone = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic shortint sat(input longint v);
    if (v > 32767)  return 16'sh7fff;
    if (v < -32768) return 16'sh8000;
    return shortint'(v);
  endfunction

  // Reference: transposed rotation with plain 64-bit arithmetic.
  function automatic exp_t model(input int x, input int y, input int z,
                                 input shortint s, input shortint c, input int due);
    exp_t e;
    longint ax, ay, az;
    ax = longint'(c) * longint'(x) + longint'(s) * longint'(y);
    ay = longint'(c) * longint'(y) - longint'(s) * longint'(x);
    az = longint'(z);
`ifdef TLINV_ROUND_EN
    ax = ax + (longint'(1) << 25);
    ay = ay + (longint'(1) << 25);
    az = az + (longint'(1) << 12);
`endif
    e.x = sat(ax >>> 26);
    e.y = sat(ay >>> 26);
    e.z = sat(az >>> 13);
    e.due = due;
    return e;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (Done) begin
      exp_t e;
      ndone++;
      check("done_while_busy", Busy, 0);
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done: got Done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("acx", AcX, e.x);
        check("acy", AcY, e.y);
        check("acz", AcZ, e.z);
        check("done_cycle", cyc, e.due);
        last = e;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!Busy) return;
    end
    checks++;
    errs++;
    $display("FAIL idle_timeout: got Busy=1 expected 0 within 20 cycles");
  endtask

  task automatic set_in(input int x, input int y, input int z, input shortint s, input shortint c);
    XAc = x; YAc = y; ZAc = z; sdseno = s; sdcoseno = c;
  endtask

  // Issue one request; inputs are scrambled after the sampling edge to prove they are latched.
  task automatic issue(input int x, input int y, input int z, input shortint s, input shortint c);
    wait_idle();
    set_in(x, y, z, s, c);
    enable = 1'b1;
    q.push_back(model(x, y, z, s, c, cyc + 6));
    @(negedge clk);
    enable = 1'b0;
    set_in($urandom, $urandom, $urandom, 16'($urandom), 16'($urandom));
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    check("drain_queue", q.size(), 0);
  endtask

  function automatic int rnd_val();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 32'h00ffffff)) - 32'sh00800000;
    return $urandom;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstart;
    rst = 1'b1;
    enable = 1'b1;
    set_in(32'sd5, 32'sd5, 32'sd5, 16'sd1, 16'sd1);
    repeat (3) @(negedge clk);
    check("rst_acx", AcX, 0);
    check("rst_acy", AcY, 0);
    check("rst_acz", AcZ, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    rst = 1'b0;
    enable = 1'b0;

    issue(8047000, 8335000, 81920, 16'sd144, 16'sd8191);
    issue(-2457600, 0, -81920, 16'sd0, 16'sd8192);
    issue(12288, 0, 12288, 16'sd0, 16'sd8192);
    issue(-12288, 0, -12288, 16'sd0, 16'sd8192);
    issue(32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff, 16'sd8192, 16'sd8192);
    issue(32'sh80000000, 32'sh80000000, 32'sh80000000, 16'sd8192, 16'sd8192);
    drain();
    repeat (4) @(negedge clk);
    check("hold_acx", AcX, last.x);
    check("hold_acy", AcY, last.y);
    check("hold_acz", AcZ, last.z);

    // Abort a conversion while in M2.
    wait_idle();
    set_in(8047000, 8335000, 81920, 16'sd144, 16'sd8191);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_in_m2", Busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_acx", AcX, 0);
    check("abort_acy", AcY, 0);
    check("abort_acz", AcZ, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    repeat (8) @(negedge clk);
    check("abort_stays_idle", Busy, 0);
    issue(8047000, 8335000, 81920, 16'sd144, 16'sd8191);
    drain();

    // Level enable held high: back-to-back conversions.
    wait_idle();
    enable = 1'b1;
    nstart = 0;
    for (int i = 0; i < 20; i++) begin
      if (!Busy) begin
        set_in(rnd_val(), rnd_val(), rnd_val(), 16'($urandom), 16'($urandom));
        q.push_back(model(XAc, YAc, ZAc, sdseno, sdcoseno, cyc + 6));
        nstart++;
      end else begin
        XAc = $urandom;
        YAc = $urandom;
      end
      @(negedge clk);
    end
    enable = 1'b0;
    check("sustained_starts", nstart, 4);
    drain();

    for (int i = 0; i < 40; i++)
      issue(rnd_val(), rnd_val(), rnd_val(), 16'($urandom), 16'($urandom));
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
